// File: rtl/sync_fifo_counted.sv
// sync_fifo_counted: single-clock first-word-fall-through FIFO with an
// occupancy counter, almost-full/almost-empty thresholds and registered
// overflow/underflow pulses. All status outputs come from the count register.
//
// Handshake: wr_en and rd_en are requests. A write is taken on a rising
// edge only when full is low at that edge; a read (pop of the word shown on
// rd_data) is taken only when empty is low. Requests made against the
// opposite flag are dropped and reported one cycle later on overflow or
// underflow. There is no pass-through: a write while full is rejected even
// if a read is taken on the same edge.
module sync_fifo_counted #(
    parameter int DATA_WIDTH          = 32,
    parameter int DEPTH               = 16,
    parameter int DATA_COUNT_WIDTH    = $clog2(DEPTH) + 1,
    parameter int ALMOST_FULL_MARGIN  = 1,
    parameter int ALMOST_EMPTY_MARGIN = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        almost_full,
    output logic [DATA_COUNT_WIDTH-1:0] wr_data_count,
    output logic                        overflow,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        empty,
    output logic                        almost_empty,
    output logic [DATA_COUNT_WIDTH-1:0] rd_data_count,
    output logic                        underflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [DATA_COUNT_WIDTH-1:0] FULL_LEVEL =
        DATA_COUNT_WIDTH'(DEPTH);
    localparam logic [DATA_COUNT_WIDTH-1:0] AF_LEVEL =
        DATA_COUNT_WIDTH'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [DATA_COUNT_WIDTH-1:0] AE_LEVEL =
        DATA_COUNT_WIDTH'(ALMOST_EMPTY_MARGIN);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_COUNT_WIDTH-1:0] CNT_ONE = DATA_COUNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [ADDR_WIDTH-1:0]       wr_ptr;
    logic [ADDR_WIDTH-1:0]       rd_ptr;
    logic [DATA_COUNT_WIDTH-1:0] count;
    logic                        wr_ok;
    logic                        rd_ok;

    // Status flags decode the count register only, so no request input has
    // a combinational path to any output.
    assign full          = (count == FULL_LEVEL);
    assign almost_full   = (count >= AF_LEVEL);
    assign empty         = (count == '0);
    assign almost_empty  = (count <= AE_LEVEL);
    assign wr_data_count = count;
    assign rd_data_count = count;

    // First-word-fall-through: the head entry is always presented.
    assign rd_data = mem[rd_ptr];

    // Acceptance looks at the registered flags, never at the other request.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage write; reset blocks the write but does not clear contents.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the rejected-request pulse flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
